// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_SUM  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes into little-endian 32-bit words; word_valid strobes
// combinationally while the last byte of a group is being accepted.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_idx_r;
  logic [23:0] shift_r;

  // Incoming byte lands on top, so the first byte of a group ends up in [7:0].
  assign word       = {data, shift_r};
  assign word_valid = accept && (byte_idx_r == LAST_BYTE);

  // Byte counter and shift register advance only on accepted bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_r <= 2'd0;
      shift_r    <= 24'd0;
    end else if (accept) begin
      byte_idx_r <= byte_idx_r + 2'd1;
      shift_r    <= word[31:8];
    end else begin
      byte_idx_r <= byte_idx_r;
      shift_r    <= shift_r;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives count, data words and checksum over a byte stream,
// writes instruction memory and releases the core after a verified load.
module prog_loader
  import loader_pkg::*;
#(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_error
);

  localparam int IDX_W = $clog2(MEM_WORDS + 1);

  state_t           state_r;
  logic [IDX_W-1:0] word_idx_r;
  logic [IDX_W-1:0] last_idx_r;
  logic [31:0]      sum_r;
  logic             accept;
  logic             word_valid;
  logic [31:0]      word;

  assign in_ready = !rst && (state_r inside {S_LEN, S_DATA, S_SUM});
  assign accept   = in_valid && in_ready;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .accept     (accept),
    .data       (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Load FSM with registered memory-write and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_LEN;
      word_idx_r <= '0;
      last_idx_r <= '0;
      sum_r      <= 32'd0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 32'd0;
      cpu_rst    <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (word_valid) begin
        case (state_r)
          S_LEN: begin
            if (word > 32'(MEM_WORDS)) begin
              state_r    <= S_ERR;
              load_error <= 1'b1;
            end else if (word == 32'd0) begin
              state_r <= S_SUM;
            end else begin
              state_r    <= S_DATA;
              last_idx_r <= IDX_W'(word - 32'd1);
            end
          end
          S_DATA: begin
            mem_we     <= 1'b1;
            mem_addr   <= BASE_ADDR + {{(30 - IDX_W){1'b0}}, word_idx_r, 2'b00};
            mem_wdata  <= word;
            sum_r      <= sum_r + word;
            word_idx_r <= word_idx_r + IDX_W'(1);
            if (word_idx_r == last_idx_r) begin
              state_r <= S_SUM;
            end else begin
              state_r <= S_DATA;
            end
          end
          S_SUM: begin
            if (word == sum_r) begin
              state_r   <= S_DONE;
              cpu_rst   <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state_r    <= S_ERR;
              load_error <= 1'b1;
            end
          end
          default: state_r <= state_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as the
// stimulus drives each data word and popped when mem_we is observed.
module tb_prog_loader;

  localparam logic [31:0] W0     = 32'h0050_0093;
  localparam logic [31:0] W1     = 32'h0010_8113;
  localparam logic [31:0] CS_OK  = 32'h0060_81A6;
  localparam logic [31:0] CS_BAD = 32'h0060_81A7;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_error;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          we_count = 0;
  logic        prev_we  = 1'b0;
  logic [31:0] words[2];

  prog_loader #(.MEM_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Write monitor: pops the scoreboard on every observed write.
  always @(negedge clk) begin
    if (mem_we) begin
      we_count++;
      if (prev_we) check("we_pulse_width", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("we_addr", mem_addr, e.addr);
        check("we_data", mem_wdata, e.data);
      end
    end
    prev_we = mem_we;
  end

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int n;
    int gap;
    gap = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
    else begin @(posedge clk); #1; end
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gapmax, input logic is_data, input int idx);
    for (int k = 0; k < 4; k++) begin
      if (is_data && k == 3) exp_q.push_back('{addr: 32'(idx * 4), data: w});
      send_byte(w[8*k +: 8], gapmax);
    end
  endtask

  task automatic send_load(input logic [31:0] n, input int ndata, input logic send_sum,
                           input logic [31:0] csum, input int gapmax);
    we_count = 0;
    send_word(n, gapmax, 1'b0, 0);
    for (int i = 0; i < ndata; i++) send_word(words[i], gapmax, 1'b1, i);
    if (send_sum) begin
      check("pre_cpu_rst", {31'd0, cpu_rst}, 32'd1);
      check("pre_done", {31'd0, load_done}, 32'd0);
      send_word(csum, gapmax, 1'b0, 0);
    end
  endtask

  task automatic end_check(input string pfx, input logic exp_done, input logic exp_err, input int exp_we);
    repeat (3) begin @(posedge clk); #1; end
    check({pfx, "_done"}, {31'd0, load_done}, {31'd0, exp_done});
    check({pfx, "_err"}, {31'd0, load_error}, {31'd0, exp_err});
    check({pfx, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, !exp_done});
    check({pfx, "_ready"}, {31'd0, in_ready}, 32'd0);
    check({pfx, "_we_count"}, 32'(we_count), 32'(exp_we));
    check({pfx, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'h0000_0000);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_done", {31'd0, load_done}, 32'd0);
    check("rst_err", {31'd0, load_error}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready_rel", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    words[0] = W0;
    words[1] = W1;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // normal load, one byte per cycle
    send_load(32'd2, 2, 1'b1, CS_OK, 0);
    check("norm_done_edge", {31'd0, load_done}, 32'd1);
    check("norm_cpu_rst_edge", {31'd0, cpu_rst}, 32'd0);
    end_check("norm", 1'b1, 1'b0, 2);

    // bad checksum
    do_reset();
    send_load(32'd2, 2, 1'b1, CS_BAD, 0);
    check("bad_err_edge", {31'd0, load_error}, 32'd1);
    end_check("bad", 1'b0, 1'b1, 2);

    // oversize count
    do_reset();
    send_load(32'd257, 0, 1'b0, 32'd0, 0);
    check("over_err_edge", {31'd0, load_error}, 32'd1);
    check("over_ready_edge", {31'd0, in_ready}, 32'd0);
    end_check("over", 1'b0, 1'b1, 0);

    // zero count
    do_reset();
    send_load(32'd0, 0, 1'b1, 32'd0, 0);
    end_check("zero", 1'b1, 1'b0, 0);

    // gapped input
    do_reset();
    send_load(32'd2, 2, 1'b1, CS_OK, 5);
    end_check("gap", 1'b1, 1'b0, 2);

    // reset after byte 6, then full reload
    do_reset();
    send_word(32'd2, 0, 1'b0, 0);
    send_byte(W0[7:0], 0);
    send_byte(W0[15:8], 0);
    do_reset();
    send_load(32'd2, 2, 1'b1, CS_OK, 0);
    end_check("midrst", 1'b1, 1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
